regs_wb_arbiter: RTL

//  Writer-side front end for the integer register file. Collects results from three

---
 rtl/regs_wb_arbiter_pkg.sv | 16 +
 rtl/regs_wb_arbiter_wb_scoreboard.sv | 52 +++++
 rtl/regs_wb_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/regs_wb_arbiter_pkg.sv
// Shared register-file constants and writeback source encoding.
// Imported by the writeback arbiter, the regfile and ID.
package regs_wb_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_ALU,
      SRC_LSU,
      SRC_MDU
   } wb_src_e;

endpackage

// File: rtl/regs_wb_arbiter_wb_scoreboard.sv
// Busy bits for destinations with a long-latency write in flight.
// Set on issue, cleared on the LSU/MDU writeback; set wins on a tie.
module wb_scoreboard
   import regs_wb_arbiter_pkg::*;
#(
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              set_en_i,
   input  logic [ADDR_W-1:0] set_rd_i,
   input  logic              clr_en_i,
   input  logic [ADDR_W-1:0] clr_rd_i,
   input  logic [ADDR_W-1:0] rs1_addr_i,
   input  logic [ADDR_W-1:0] rs2_addr_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic              rs1_busy_o,
   output logic              rs2_busy_o,
   output logic              rd_busy_o
);

   localparam int NREG = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic            set_ok;

   assign set_ok = set_en_i && (set_rd_i != ZERO);

   always_comb begin
      busy_d = busy_q;
      if (clr_en_i) busy_d[clr_rd_i] = 1'b0;
      if (set_ok) busy_d[set_rd_i] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign rs1_busy_o = busy_q[rs1_addr_i];
   assign rs2_busy_o = busy_q[rs2_addr_i];
   assign rd_busy_o  = busy_q[rd_addr_i];

   // Re-issuing a busy rd is only legal when its writeback retires now.
   ill_issue_a: assert property (@(posedge clk) disable iff (!rst_n)
      (set_ok && !(clr_en_i && clr_rd_i == set_rd_i))
         |-> !busy_q[set_rd_i]);

endmodule

// File: rtl/regs_wb_arbiter.sv
// Writeback arbiter: ALU > LSU > MDU onto the regfile write port,
// with MDU starvation promotion and the long-latency scoreboard.
module regs_wb_arbiter
   import regs_wb_arbiter_pkg::*;
#(
   parameter int DATA_W       = REG_DATA_W,
   parameter int ADDR_W       = REG_ADDR_W,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid_i,
   output logic              alu_ready_o,
   input  logic [ADDR_W-1:0] alu_rd_i,
   input  logic [DATA_W-1:0] alu_data_i,
   input  logic              lsu_valid_i,
   output logic              lsu_ready_o,
   input  logic [ADDR_W-1:0] lsu_rd_i,
   input  logic [DATA_W-1:0] lsu_data_i,
   input  logic              mdu_valid_i,
   output logic              mdu_ready_o,
   input  logic [ADDR_W-1:0] mdu_rd_i,
   input  logic [DATA_W-1:0] mdu_data_i,
   input  logic              issue_valid_i,
   input  logic [ADDR_W-1:0] issue_rd_i,
   input  logic [ADDR_W-1:0] rs1_addr_i,
   input  logic [ADDR_W-1:0] rs2_addr_i,
   output logic              rs1_busy_o,
   output logic              rs2_busy_o,
   output logic              rd_busy_o,
   output logic              reg_wen_o,
   output logic [ADDR_W-1:0] reg_waddr_o,
   output logic [DATA_W-1:0] reg_wdata_o
);

   // Wide enough to actually hold STARVE_LIMIT.
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   typedef logic [CNT_W-1:0] cnt_t;
   localparam cnt_t CNT_MAX = cnt_t'(STARVE_LIMIT);
   localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

   wb_src_e           src;
   logic              gnt;
   logic [ADDR_W-1:0] gnt_rd;
   logic [DATA_W-1:0] gnt_data;

   cnt_t              starve_q, starve_d;
   logic              wen_q, wen_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   always_comb begin
      src = SRC_NONE;
      if (rst_n) begin
         if (mdu_valid_i && starve_q == CNT_MAX) src = SRC_MDU;
         else if (alu_valid_i)                   src = SRC_ALU;
         else if (lsu_valid_i)                   src = SRC_LSU;
         else if (mdu_valid_i)                   src = SRC_MDU;
      end
   end

   assign alu_ready_o = (src == SRC_ALU);
   assign lsu_ready_o = (src == SRC_LSU);
   assign mdu_ready_o = (src == SRC_MDU);
   assign gnt         = (src != SRC_NONE);

   always_comb begin
      gnt_rd   = '0;
      gnt_data = '0;
      case (src)
         SRC_ALU: begin
            gnt_rd   = alu_rd_i;
            gnt_data = alu_data_i;
         end
         SRC_LSU: begin
            gnt_rd   = lsu_rd_i;
            gnt_data = lsu_data_i;
         end
         SRC_MDU: begin
            gnt_rd   = mdu_rd_i;
            gnt_data = mdu_data_i;
         end
         default: ;
      endcase
   end

   always_comb begin
      starve_d = starve_q;
      if (!mdu_valid_i || mdu_ready_o) starve_d = '0;
      else if (starve_q != CNT_MAX)    starve_d = starve_q + cnt_t'(1);
      wen_d   = gnt && (gnt_rd != ZERO);
      waddr_d = gnt ? gnt_rd : waddr_q;
      wdata_d = gnt ? gnt_data : wdata_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_q <= '0;
         wen_q    <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
      end else begin
         starve_q <= starve_d;
         wen_q    <= wen_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
      end
   end

   assign reg_wen_o   = wen_q;
   assign reg_waddr_o = waddr_q;
   assign reg_wdata_o = wdata_q;

   wb_scoreboard #(
      .ADDR_W (ADDR_W)
   ) u_sb (
      .clk        (clk),
      .rst_n      (rst_n),
      .set_en_i   (issue_valid_i),
      .set_rd_i   (issue_rd_i),
      .clr_en_i   (lsu_ready_o || mdu_ready_o),
      .clr_rd_i   (gnt_rd),
      .rs1_addr_i (rs1_addr_i),
      .rs2_addr_i (rs2_addr_i),
      .rd_addr_i  (issue_rd_i),
      .rs1_busy_o (rs1_busy_o),
      .rs2_busy_o (rs2_busy_o),
      .rd_busy_o  (rd_busy_o)
   );

endmodule
